// File: rtl/bids_nway.sv
// bids_nway -- N-bidder sealed-bid auction controller.
//
// A single controller port configures per-bidder balances, the bidder mask,
// the penalty timer and the per-bid charge, then locks the block with a key.
// While locked, C_start high opens a round. Bidders place or retract bids,
// and each accepted bid costs bid_cost. When C_start falls, the block
// resolves a unique maximum bidder and debits the winning amount from that
// bidder's balance.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   C_op, C_data, C_sel controller opcode, operand, bidder index (LoadBal)
//   C_start             round active level
//   bid, bidAmt, retract per-bidder bid strobe, packed amounts, retract strobe
//   ready               accepting controller ops (low in reset and PENALTY)
//   err                 controller error code pulse
//   ack, bidder_err     per-bidder bid-accepted pulse / 2-bit error pulse
//   balance             packed per-bidder balances
//   win, maxBid         one-hot winner and winning amount (held)
//   roundOver           round-resolved pulse
module bids_nway #(
    parameter int NUM_BIDDERS = 4,
    parameter int VALUE_W     = 32,
    parameter int BID_W       = 16,
    parameter int SEL_W       = $clog2(NUM_BIDDERS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [3:0]                     C_op,
    input  logic [VALUE_W-1:0]             C_data,
    input  logic [SEL_W-1:0]               C_sel,
    input  logic                           C_start,
    input  logic [NUM_BIDDERS-1:0]         bid,
    input  logic [NUM_BIDDERS*BID_W-1:0]   bidAmt,
    input  logic [NUM_BIDDERS-1:0]         retract,
    output logic                           ready,
    output logic [2:0]                     err,
    output logic [NUM_BIDDERS-1:0]         ack,
    output logic [2*NUM_BIDDERS-1:0]       bidder_err,
    output logic [NUM_BIDDERS*VALUE_W-1:0] balance,
    output logic [NUM_BIDDERS-1:0]         win,
    output logic [BID_W-1:0]               maxBid,
    output logic                           roundOver
);

    localparam logic [3:0] OP_NOOP      = 4'd0;
    localparam logic [3:0] OP_UNLOCK    = 4'd1;
    localparam logic [3:0] OP_LOCK      = 4'd2;
    localparam logic [3:0] OP_LOADBAL   = 4'd3;
    localparam logic [3:0] OP_SETMASK   = 4'd6;
    localparam logic [3:0] OP_SETTIMER  = 4'd7;
    localparam logic [3:0] OP_BIDCHARGE = 4'd8;

    localparam logic [2:0] E_OK        = 3'b000;
    localparam logic [2:0] E_UNLOCKED  = 3'b010;
    localparam logic [2:0] E_START_UL  = 3'b011;
    localparam logic [2:0] E_BAD_OP    = 3'b100;
    localparam logic [2:0] E_TIE       = 3'b101;
    localparam logic [2:0] E_WRONG_KEY = 3'b110;
    localparam logic [2:0] E_LOCKED_OP = 3'b111;

    localparam logic [1:0] BE_INACTIVE = 2'b01;
    localparam logic [1:0] BE_FUNDS    = 2'b10;
    localparam logic [1:0] BE_MASKED   = 2'b11;

    typedef enum logic [2:0] {
        S_UNLOCKED,
        S_LOCKED,
        S_ROUND,
        S_RESULT,
        S_PENALTY
    } state_t;

    state_t                   state;
    logic [VALUE_W-1:0]       bal [NUM_BIDDERS];
    logic [NUM_BIDDERS-1:0]   mask;
    logic [VALUE_W-1:0]       timer;
    logic [VALUE_W-1:0]       bid_cost;
    logic [VALUE_W-1:0]       key;
    logic [VALUE_W-1:0]       pen_cnt;
    logic [NUM_BIDDERS-1:0]   rb_vld;
    logic [BID_W-1:0]         rb_amt [NUM_BIDDERS];

    // Resolution result, derived from the bids held at round close.
    logic [BID_W-1:0]         top_amt;
    logic [SEL_W-1:0]         top_idx;
    logic                     top_any;
    logic                     top_tie;
    logic                     sel_ok;

    // Funds check is widened by one bit so amount + cost can never wrap.
    function automatic logic can_afford(input logic [VALUE_W-1:0] b,
                                        input logic [BID_W-1:0]   amt,
                                        input logic [VALUE_W-1:0] cost);
        return {1'b0, b} >= ({1'b0, VALUE_W'(amt)} + {1'b0, cost});
    endfunction

    assign sel_ok = (32'(C_sel) < NUM_BIDDERS);

    for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_bal
        assign balance[g*VALUE_W +: VALUE_W] = bal[g];
    end

    // First pass finds the maximum held bid; second pass finds who holds it
    // and whether more than one bidder does.
    always_comb begin
        logic hit;
        top_amt = '0;
        top_any = 1'b0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (rb_vld[i] && (!top_any || rb_amt[i] > top_amt)) begin
                top_amt = rb_amt[i];
                top_any = 1'b1;
            end
        end
        hit     = 1'b0;
        top_tie = 1'b0;
        top_idx = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (rb_vld[i] && rb_amt[i] == top_amt) begin
                if (hit) top_tie = 1'b1;
                hit     = 1'b1;
                top_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_UNLOCKED;
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                bal[i]    <= '0;
                rb_amt[i] <= '0;
            end
            mask       <= '1;
            timer      <= VALUE_W'(32'hF);
            bid_cost   <= VALUE_W'(1);
            key        <= '0;
            pen_cnt    <= '0;
            rb_vld     <= '0;
            ready      <= 1'b0;
            err        <= E_OK;
            ack        <= '0;
            bidder_err <= '0;
            win        <= '0;
            maxBid     <= '0;
            roundOver  <= 1'b0;
        end else begin
            // Pulse outputs default low; ready is high everywhere but PENALTY.
            err        <= E_OK;
            ack        <= '0;
            bidder_err <= '0;
            roundOver  <= 1'b0;
            ready      <= 1'b1;

            // Outside an open round every bid or retract is rejected as
            // inactive; ROUND overrides this per bidder below.
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (bid[i] || retract[i]) bidder_err[2*i +: 2] <= BE_INACTIVE;
            end

            case (state)
                S_UNLOCKED: begin
                    case (C_op)
                        OP_NOOP:      ;
                        OP_UNLOCK:    err <= E_UNLOCKED;
                        OP_LOCK: begin
                            key   <= C_data;
                            state <= S_LOCKED;
                        end
                        OP_LOADBAL: begin
                            if (sel_ok) bal[C_sel] <= C_data;
                            else        err <= E_BAD_OP;
                        end
                        OP_SETMASK:   mask     <= C_data[NUM_BIDDERS-1:0];
                        OP_SETTIMER:  timer    <= C_data;
                        OP_BIDCHARGE: bid_cost <= C_data;
                        default:      err <= E_BAD_OP;
                    endcase
                    // Starting a round while unlocked is reported in preference
                    // to any op error; the op itself still takes effect.
                    if (C_start) err <= E_START_UL;
                end

                S_LOCKED: begin
                    if (C_start) begin
                        state  <= S_ROUND;
                        rb_vld <= '0;
                        win    <= '0;
                        maxBid <= '0;
                    end else begin
                        case (C_op)
                            OP_NOOP: ;
                            OP_UNLOCK: begin
                                if (C_data == key) begin
                                    state <= S_UNLOCKED;
                                end else begin
                                    err     <= E_WRONG_KEY;
                                    pen_cnt <= timer;
                                    state   <= S_PENALTY;
                                    ready   <= 1'b0;
                                end
                            end
                            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                                err <= E_LOCKED_OP;
                            default: err <= E_BAD_OP;
                        endcase
                    end
                end

                S_ROUND: begin
                    if (C_op >= 4'd1 && C_op <= 4'd8) err <= E_LOCKED_OP;
                    if (!C_start) begin
                        // Closing cycle: bids stay flagged inactive, unrecorded.
                        state <= S_RESULT;
                    end else begin
                        for (int i = 0; i < NUM_BIDDERS; i++) begin
                            bidder_err[2*i +: 2] <= 2'b00;
                            if (retract[i]) begin
                                rb_vld[i] <= 1'b0;
                            end else if (bid[i] && !mask[i]) begin
                                bidder_err[2*i +: 2] <= BE_MASKED;
                            end else if (bid[i] &&
                                         can_afford(bal[i], bidAmt[i*BID_W +: BID_W], bid_cost)) begin
                                rb_vld[i] <= 1'b1;
                                rb_amt[i] <= bidAmt[i*BID_W +: BID_W];
                                bal[i]    <= bal[i] - bid_cost;
                                ack[i]    <= 1'b1;
                            end else if (bid[i]) begin
                                bidder_err[2*i +: 2] <= BE_FUNDS;
                            end
                        end
                    end
                end

                S_RESULT: begin
                    roundOver <= 1'b1;
                    state     <= S_LOCKED;
                    if (top_any && !top_tie) begin
                        win          <= '0;
                        win[top_idx] <= 1'b1;
                        maxBid       <= top_amt;
                        bal[top_idx] <= bal[top_idx] - VALUE_W'(top_amt);
                    end else begin
                        win    <= '0;
                        maxBid <= '0;
                        if (top_tie) err <= E_TIE;
                    end
                end

                S_PENALTY: begin
                    // A count of 0 or 1 both leave after this cycle, so a zero
                    // timer still costs one cycle of lockout.
                    if (pen_cnt <= VALUE_W'(1)) begin
                        state <= S_LOCKED;
                    end else begin
                        pen_cnt <= pen_cnt - VALUE_W'(1);
                        ready   <= 1'b0;
                    end
                end

                default: state <= S_UNLOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_bids_nway.sv
// Directed testbench for bids_nway (4 bidders, 32-bit values, 16-bit bids).
module tb_bids_nway;

    localparam int NB = 4;
    localparam int VW = 32;
    localparam int BW = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      C_op;
    logic [VW-1:0]   C_data;
    logic [SW-1:0]   C_sel;
    logic            C_start;
    logic [NB-1:0]   bid;
    logic [NB*BW-1:0] bidAmt;
    logic [NB-1:0]   retract;
    logic            ready;
    logic [2:0]      err;
    logic [NB-1:0]   ack;
    logic [2*NB-1:0] bidder_err;
    logic [NB*VW-1:0] balance;
    logic [NB-1:0]   win;
    logic [BW-1:0]   maxBid;
    logic            roundOver;

    int vectors = 0;
    int miscompares = 0;

    bids_nway #(.NUM_BIDDERS(NB), .VALUE_W(VW), .BID_W(BW), .SEL_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .C_op(C_op), .C_data(C_data), .C_sel(C_sel),
        .C_start(C_start), .bid(bid), .bidAmt(bidAmt), .retract(retract),
        .ready(ready), .err(err), .ack(ack), .bidder_err(bidder_err),
        .balance(balance), .win(win), .maxBid(maxBid), .roundOver(roundOver)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        C_op = 4'd0; C_data = '0; C_sel = '0;
        bid = '0; retract = '0; bidAmt = '0;
    endtask

    function automatic logic [VW-1:0] bal_of(input int i);
        return balance[i*VW +: VW];
    endfunction

    task automatic set_amt(input int i, input logic [BW-1:0] v);
        bidAmt[i*BW +: BW] = v;
    endtask

    task automatic op(input logic [3:0] o, input logic [VW-1:0] d, input logic [SW-1:0] s);
        idle();
        C_op = o; C_data = d; C_sel = s;
        cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; C_start = 1'b0; idle();
        cycle(); cycle();
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%0b exp=0", ready); end
        vectors++; if (err !== 3'b000 || ack !== 4'b0 || bidder_err !== 8'h00) begin
            miscompares++; $display("FAIL rst_pulses got err=%0b ack=%0b berr=%0h exp 0", err, ack, bidder_err); end
        vectors++; if (win !== 4'b0 || maxBid !== 16'd0 || roundOver !== 1'b0) begin
            miscompares++; $display("FAIL rst_result got win=%0b max=%0d ro=%0b exp 0", win, maxBid, roundOver); end
        vectors++; if (balance !== '0) begin miscompares++; $display("FAIL rst_balance got=%0h exp=0", balance); end
        reset_n = 1'b1;
        cycle();
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got=%0b exp=1", ready); end
    endtask

    task automatic test_config();
        op(4'd3, 32'd100, 2'd0);
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL cfg_load0_err got=%0b exp=000", err); end
        op(4'd3, 32'd50, 2'd1);
        op(4'd6, 32'h3, 2'd0);
        op(4'd7, 32'd3, 2'd0);
        op(4'd2, 32'hABCD, 2'd0);
        vectors++; if (err !== 3'b000 || ready !== 1'b1) begin
            miscompares++; $display("FAIL cfg_lock got err=%0b ready=%0b exp 000/1", err, ready); end
        idle(); cycle();
        vectors++; if (bal_of(0) !== 32'd100) begin miscompares++; $display("FAIL cfg_bal0 got=%0d exp=100", bal_of(0)); end
        vectors++; if (bal_of(1) !== 32'd50) begin miscompares++; $display("FAIL cfg_bal1 got=%0d exp=50", bal_of(1)); end
    endtask

    task automatic test_round_win();
        idle(); C_start = 1'b1; cycle();
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rw_ready got=%0b exp=1", ready); end
        bid = 4'b0011; set_amt(0, 16'd40); set_amt(1, 16'd30); cycle();
        vectors++; if (ack !== 4'b0011 || bidder_err !== 8'h00) begin
            miscompares++; $display("FAIL rw_ack got ack=%0b berr=%0h exp 0011/00", ack, bidder_err); end
        vectors++; if (bal_of(0) !== 32'd99 || bal_of(1) !== 32'd49) begin
            miscompares++; $display("FAIL rw_charge got=%0d/%0d exp=99/49", bal_of(0), bal_of(1)); end
        idle(); C_start = 1'b0; cycle();
        vectors++; if (roundOver !== 1'b0) begin miscompares++; $display("FAIL rw_ro_early got=%0b exp=0", roundOver); end
        cycle();
        vectors++; if (roundOver !== 1'b1 || win !== 4'b0001 || maxBid !== 16'd40 || err !== 3'b000) begin
            miscompares++; $display("FAIL rw_result got ro=%0b win=%0b max=%0d err=%0b exp 1/0001/40/000", roundOver, win, maxBid, err); end
        vectors++; if (bal_of(0) !== 32'd59 || bal_of(1) !== 32'd49) begin
            miscompares++; $display("FAIL rw_debit got=%0d/%0d exp=59/49", bal_of(0), bal_of(1)); end
        cycle();
        vectors++; if (roundOver !== 1'b0 || win !== 4'b0001 || maxBid !== 16'd40) begin
            miscompares++; $display("FAIL rw_hold got ro=%0b win=%0b max=%0d exp 0/0001/40", roundOver, win, maxBid); end
    endtask

    task automatic test_funds_mask_retract();
        idle(); C_start = 1'b1; cycle();
        vectors++; if (win !== 4'b0 || maxBid !== 16'd0) begin
            miscompares++; $display("FAIL fm_clear got win=%0b max=%0d exp 0/0", win, maxBid); end
        bid = 4'b0010; set_amt(1, 16'd49); cycle();
        vectors++; if (bidder_err !== 8'h08 || ack !== 4'b0 || bal_of(1) !== 32'd49) begin
            miscompares++; $display("FAIL fm_funds got berr=%0h ack=%0b bal1=%0d exp 08/0/49", bidder_err, ack, bal_of(1)); end
        idle(); bid = 4'b0100; set_amt(2, 16'd5); cycle();
        vectors++; if (bidder_err !== 8'h30 || ack !== 4'b0) begin
            miscompares++; $display("FAIL fm_masked got berr=%0h ack=%0b exp 30/0", bidder_err, ack); end
        idle(); bid = 4'b0001; set_amt(0, 16'd10); C_op = 4'd3; cycle();
        vectors++; if (ack !== 4'b0001 || err !== 3'b111 || bal_of(0) !== 32'd58) begin
            miscompares++; $display("FAIL fm_bid0 got ack=%0b err=%0b bal0=%0d exp 0001/111/58", ack, err, bal_of(0)); end
        idle(); bid = 4'b0001; retract = 4'b0001; set_amt(0, 16'd50); cycle();
        vectors++; if (ack !== 4'b0 || bidder_err !== 8'h00 || bal_of(0) !== 32'd58) begin
            miscompares++; $display("FAIL fm_retract got ack=%0b berr=%0h bal0=%0d exp 0/00/58", ack, bidder_err, bal_of(0)); end
        idle(); bid = 4'b0010; set_amt(1, 16'd5); cycle();
        vectors++; if (ack !== 4'b0010 || bal_of(1) !== 32'd48) begin
            miscompares++; $display("FAIL fm_bid1 got ack=%0b bal1=%0d exp 0010/48", ack, bal_of(1)); end
        idle(); C_start = 1'b0; bid = 4'b0001; set_amt(0, 16'd7); cycle();
        vectors++; if (bidder_err !== 8'h01 || ack !== 4'b0) begin
            miscompares++; $display("FAIL fm_close_bid got berr=%0h ack=%0b exp 01/0", bidder_err, ack); end
        idle(); cycle();
        vectors++; if (roundOver !== 1'b1 || win !== 4'b0010 || maxBid !== 16'd5) begin
            miscompares++; $display("FAIL fm_result got ro=%0b win=%0b max=%0d exp 1/0010/5", roundOver, win, maxBid); end
        vectors++; if (bal_of(0) !== 32'd58 || bal_of(1) !== 32'd43) begin
            miscompares++; $display("FAIL fm_debit got=%0d/%0d exp=58/43", bal_of(0), bal_of(1)); end
    endtask

    task automatic test_tie();
        idle(); C_start = 1'b1; cycle();
        bid = 4'b0011; set_amt(0, 16'd20); set_amt(1, 16'd20); cycle();
        vectors++; if (ack !== 4'b0011 || bal_of(0) !== 32'd57 || bal_of(1) !== 32'd42) begin
            miscompares++; $display("FAIL tie_bids got ack=%0b bal=%0d/%0d exp 0011/57/42", ack, bal_of(0), bal_of(1)); end
        idle(); C_start = 1'b0; cycle();
        cycle();
        vectors++; if (roundOver !== 1'b1 || err !== 3'b101 || win !== 4'b0 || maxBid !== 16'd0) begin
            miscompares++; $display("FAIL tie_result got ro=%0b err=%0b win=%0b max=%0d exp 1/101/0/0", roundOver, err, win, maxBid); end
        vectors++; if (bal_of(0) !== 32'd57 || bal_of(1) !== 32'd42) begin
            miscompares++; $display("FAIL tie_nodebit got=%0d/%0d exp=57/42", bal_of(0), bal_of(1)); end
    endtask

    task automatic test_penalty();
        op(4'd1, 32'h1234, 2'd0);
        vectors++; if (err !== 3'b110 || ready !== 1'b0) begin
            miscompares++; $display("FAIL pen_enter got err=%0b ready=%0b exp 110/0", err, ready); end
        idle(); C_op = 4'd1; C_data = 32'hABCD; cycle();
        vectors++; if (ready !== 1'b0 || err !== 3'b000) begin
            miscompares++; $display("FAIL pen_c1 got ready=%0b err=%0b exp 0/000", ready, err); end
        idle(); cycle();
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL pen_c2 got ready=%0b exp 0", ready); end
        cycle();
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL pen_exit got ready=%0b exp 1", ready); end
        op(4'd1, 32'hABCD, 2'd0);
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL pen_unlock got err=%0b exp 000", err); end
        op(4'd1, 32'h0, 2'd0);
        vectors++; if (err !== 3'b010) begin miscompares++; $display("FAIL pen_reunlock got err=%0b exp 010", err); end
    endtask

    task automatic test_errors();
        idle(); C_start = 1'b1; C_op = 4'd9; cycle();
        vectors++; if (err !== 3'b011) begin miscompares++; $display("FAIL er_start got err=%0b exp 011", err); end
        idle(); C_start = 1'b0; C_op = 4'd9; cycle();
        vectors++; if (err !== 3'b100) begin miscompares++; $display("FAIL er_badop got err=%0b exp 100", err); end
        idle(); bid = 4'b1000; cycle();
        vectors++; if (bidder_err !== 8'h40 || ack !== 4'b0) begin
            miscompares++; $display("FAIL er_unl_bid got berr=%0h ack=%0b exp 40/0", bidder_err, ack); end
    endtask

    task automatic test_reset_midround();
        op(4'd3, 32'd10, 2'd0);
        op(4'd2, 32'd0, 2'd0);
        idle(); C_start = 1'b1; cycle();
        bid = 4'b0001; set_amt(0, 16'd3); cycle();
        vectors++; if (ack !== 4'b0001 || bal_of(0) !== 32'd9) begin
            miscompares++; $display("FAIL rm_bid got ack=%0b bal0=%0d exp 0001/9", ack, bal_of(0)); end
        idle(); reset_n = 1'b0; cycle();
        vectors++; if (ready !== 1'b0 || err !== 3'b0 || ack !== 4'b0 || bidder_err !== 8'h00 ||
                       win !== 4'b0 || maxBid !== 16'd0 || roundOver !== 1'b0 || balance !== '0) begin
            miscompares++; $display("FAIL rm_reset got ready=%0b err=%0b ack=%0b win=%0b max=%0d ro=%0b bal=%0h exp all 0",
                                    ready, err, ack, win, maxBid, roundOver, balance); end
        reset_n = 1'b1; cycle();
        cycle();
        vectors++; if (err !== 3'b011) begin miscompares++; $display("FAIL rm_unlocked got err=%0b exp 011", err); end
        C_start = 1'b0; cycle();
    endtask

    initial begin
        reset_n = 1'b0; C_start = 1'b0; idle();
        test_reset();
        test_config();
        test_round_win();
        test_funds_mask_retract();
        test_tie();
        test_penalty();
        test_errors();
        test_reset_midround();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
